// File: rtl/hazard_controller.sv
// hazard_controller: RAW-stall and branch-flush sequencing for an in-order pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module hazard_controller #(
    parameter int selectionBits = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic [selectionBits-1:0] dec_rsel1,
    input  logic [selectionBits-1:0] dec_rsel2,
    input  logic                     dec_use1,
    input  logic                     dec_use2,
    input  logic                     dec_wr,
    input  logic [selectionBits-1:0] dec_rd,
    input  logic                     dec_branch,
    input  logic                     mem_pc_wr,
    output logic                     pc_hold,
    output logic                     fd_hold,
    output logic                     fd_flush,
    output logic                     dx_bubble,
    output logic                     issue,
    output logic [1:0]               state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              flush_cnt
`endif
);

    // Handshake: issue=1 means the decode instruction is accepted into execute at
    // this rising edge; while issue=0 with dec_valid=1 the instruction must be held.

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BR_W1 = 2'd1,
        BR_W2 = 2'd2
    } ctrlState_t;

    typedef struct packed {
        logic                     valid;
        logic [selectionBits-1:0] rd;
    } sbEntry_t;

    ctrlState_t curState;
    ctrlState_t nextState;
    sbEntry_t   sb [0:2];

    logic match1;
    logic match2;
    logic hazard;
    logic stallNow;
    logic issueRaw;
    logic pcHoldRaw;
    logic fdHoldRaw;
    logic fdFlushRaw;
    logic dxBubbleRaw;

    // sb2 still matters: the register file is written at the same edge it retires.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb[i].valid && (sb[i].rd == dec_rsel1)) match1 = 1'b1;
            if (sb[i].valid && (sb[i].rd == dec_rsel2)) match2 = 1'b1;
        end
    end

    assign hazard = dec_valid & ((dec_use1 & match1) | (dec_use2 & match2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curState <= RUN;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState   = curState;
        stallNow    = 1'b0;
        issueRaw    = 1'b0;
        pcHoldRaw   = 1'b0;
        fdHoldRaw   = 1'b0;
        fdFlushRaw  = 1'b0;
        dxBubbleRaw = 1'b0;
        case (curState)
            RUN: begin
                if (hazard) begin
                    stallNow    = 1'b1;
                    pcHoldRaw   = 1'b1;
                    fdHoldRaw   = 1'b1;
                    dxBubbleRaw = 1'b1;
                end else if (dec_valid) begin
                    issueRaw = 1'b1;
                    if (dec_branch) begin
                        pcHoldRaw  = 1'b1;
                        fdFlushRaw = 1'b1;
                        nextState  = BR_W1;
                    end
                end
            end
            BR_W1: begin
                pcHoldRaw   = 1'b1;
                fdFlushRaw  = 1'b1;
                dxBubbleRaw = 1'b1;
                nextState   = BR_W2;
            end
            BR_W2: begin
                // Branch resolves in memory now; only a taken branch kills the fetched slot.
                dxBubbleRaw = 1'b1;
                fdFlushRaw  = mem_pc_wr;
                nextState   = RUN;
            end
            default: begin
                nextState = RUN;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    assign issue     = rst & issueRaw;
    assign pc_hold   = rst & pcHoldRaw;
    assign fd_flush  = rst & fdFlushRaw;
    assign fd_hold   = rst & fdHoldRaw & ~fdFlushRaw;
    assign dx_bubble = rst & dxBubbleRaw;
    assign state     = curState;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[2] <= sb[1];
            sb[1] <= sb[0];
            sb[0] <= '{valid: issue & dec_wr, rd: dec_rd};
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallNow && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (fd_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter selectionBits, default 4, register-select width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port dec_valid  input  1  decode-stage instruction is real (0 = NOP/bubble).
REQ-005 SHALL have ports dec_rsel1, dec_rsel2  input  selectionBits  source registers read in decode.
REQ-006 SHALL have ports dec_use1, dec_use2  input  1  the corresponding source is actually read.
REQ-007 SHALL have port dec_wr  input  1  instruction writes a register (scalar OR vector enable).
REQ-008 SHALL have port dec_rd  input  selectionBits  destination register.
REQ-009 SHALL have port dec_branch  input  1  instruction writes PC (any non-zero PC-write code).
REQ-010 SHALL have port mem_pc_wr  input  1  branch in memory stage is taken (PC written this edge).
REQ-011 SHALL have ports pc_hold, fd_hold, fd_flush, dx_bubble  output  1  hold PC; hold fetch/decode pipe; load NOP into fetch/decode pipe; load NOP into decode/execute pipe.
REQ-012 SHALL have port issue  output  1  decode instruction advances to execute this cycle.
REQ-013 SHALL have port state  output  2  RUN=0, BR_W1=1, BR_W2=2.

Function
REQ-014 SHALL keep a 3-entry scoreboard {valid, rd} for execute (sb0), memory (sb1) and register-write (sb2) stages.
REQ-015 SHALL shift it every cycle: sb2<=sb1, sb1<=sb0, sb0<={issue & dec_wr, dec_rd}.
REQ-016 SHALL flag hazard = dec_valid & ((dec_use1 & rsel1 matches any valid sbN.rd) | (dec_use2 & rsel2 matches any valid sbN.rd)); sb2 counts because the register file writes at that edge.
REQ-017 SHALL, on hazard in RUN: pc_hold=1, fd_hold=1, dx_bubble=1, issue=0; stall lasts until the matching entry leaves sb2 (max 3 cycles).
REQ-018 SHALL set issue = dec_valid & ~hazard in RUN and 0 in BR_W1/BR_W2.
REQ-019 SHALL, in RUN with issue & dec_branch: pc_hold=1, fd_flush=1, next state BR_W1.
REQ-020 SHALL, in BR_W1: pc_hold=1, fd_flush=1, dx_bubble=1; next state BR_W2.
REQ-021 SHALL, in BR_W2: pc_hold=0, dx_bubble=1, fd_flush=mem_pc_wr; next state RUN.
REQ-022 SHALL therefore give a taken-branch penalty of 3 bubbles and a not-taken penalty of 2.
REQ-023 SHALL let fd_flush override fd_hold when both are asserted.
REQ-024 SHALL ignore mem_pc_wr outside BR_W2.
REQ-025 SHALL ignore dec_branch when dec_valid=0 or when hazard=1 (the branch issues later).
REQ-026 SHALL drive all outputs combinationally from the state register, the scoreboard and the current inputs; the only registers are state, the scoreboard and the optional counters.

Reset
REQ-027 SHALL, while rst=0: state=RUN, all scoreboard valid bits=0, counters=0.
REQ-028 SHALL hold outputs at pc_hold=fd_hold=fd_flush=dx_bubble=issue=0 while rst=0, regardless of the other inputs.
REQ-029 SHALL abandon any pending branch or stall on rst assertion, with no replay after release.

Configuration
REQ-030 SHALL, when macro HAZARD_PERF_CNT_EN is defined, add outputs stall_cnt[15:0] (increments on cycles with hazard stall) and flush_cnt[15:0] (increments on cycles with fd_flush=1), both saturating at 16'hFFFF.
REQ-031 SHALL, without HAZARD_PERF_CNT_EN, have neither port nor counter logic, with identical remaining behaviour.

Verification
REQ-032 SHALL cover: write r3 issued, next instruction reads r3 via rsel1 -> 3 stall cycles (pc_hold=fd_hold=dx_bubble=1), issue=1 on the 4th cycle.
REQ-033 SHALL cover: write r3, independent instruction, then read r3 -> exactly 2 stall cycles.
REQ-034 SHALL cover: branch issued, mem_pc_wr=1 in BR_W2 -> states RUN->BR_W1->BR_W2->RUN, fd_flush high for 3 cycles, pc_hold low in BR_W2.
REQ-035 SHALL cover: branch issued, mem_pc_wr=0 in BR_W2 -> fd_flush low in BR_W2, next instruction issues on the following cycle.
REQ-036 SHALL cover: rst dropped in BR_W1 with sb0 valid -> state=0, all outputs 0, and a read of that register after release issues without stall.
REQ-037 SHALL cover, with HAZARD_PERF_CNT_EN: 70000 forced hazard cycles -> stall_cnt=16'hFFFF; one taken branch -> flush_cnt=3.
